key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Consumes the debounced, active-low key level produced by the board's key debouncer and turns it into single-cycle event strobes: press, release, short press, long press and auto-repeat while held. It is the consumer end of the debounced-key interface and feeds menu/control FSMs that need clean events rather than levels. Fully synchronous to the 50 MHz system clock; no internal filtering (input is already debounced).

## Interface

- LONG_CYC, 50_000_000 — hold time in clk cycles before a press counts as long (1 s at 50 MHz); legal range 2 .. 2^CNT_W-1
- REPEAT_CYC, 10_000_000 — repeat interval in clk cycles after long detection (200 ms); legal range 2 .. 2^CNT_W-1
- REPEAT_EN, 1 — 1: generate repeat_pulse while held past long; 0: no repeat_pulse ever
- CNT_W, 26 — hold counter width
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, asynchronous, active-low
- key_xd  input  1  debounced key level, 0 = pressed, 1 = released; synchronous to clk
- press_pulse  output  1  one-cycle strobe on key press
- release_pulse  output  1  one-cycle strobe on key release
- short_pulse  output  1  one-cycle strobe on release before long threshold
- long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYC
- repeat_pulse  output  1  one-cycle strobe every REPEAT_CYC while held past long
- held  output  1  level, 1 while decoder is in PRESS or LONG

## Operation

- Reset: state IDLE, key_d (previous key_xd) = 1, cnt = 0, all outputs 0.
- Edge detect on key_xd vs key_d; key_d <= key_xd every cycle. Fall = key_d==1 & key_xd==0; key low = key_xd==0.
- All outputs registered; default every strobe to 0 each cycle (no strobe lasts more than one cycle).
- IDLE: on fall -> press_pulse<=1, held<=1, cnt<=0, go PRESS. Otherwise stay.
- PRESS: if key_xd==1 -> release_pulse<=1, short_pulse<=1, held<=0, go IDLE. Else if cnt==LONG_CYC-1 -> long_pulse<=1, cnt<=0, go LONG. Else cnt<=cnt+1.
- LONG: if key_xd==1 -> release_pulse<=1, held<=0, go IDLE (no short_pulse). Else if REPEAT_EN & cnt==REPEAT_CYC-1 -> repeat_pulse<=1, cnt<=0. Else cnt<=cnt+1 (with REPEAT_EN=0, cnt saturates at REPEAT_CYC-1; no wrap).
- Priority: release beats long threshold and repeat threshold on the same edge.
- cnt never wraps: cleared on every threshold hit and on press.
- Key low out of reset: key_d resets to 1, so a key_xd of 0 at the first clk edge after reset release counts as a fall and yields press_pulse.
- Reset asserted mid-press: immediate return to IDLE, all outputs 0; no release_pulse is generated for the aborted press.
- Short press and long press are mutually exclusive per press; exactly one press_pulse and one release_pulse per press.

## Timing

- Let edge E = first clk edge sampling key_xd==0 after it was 1. press_pulse and held rise after E (high during cycle E..E+1).
- long_pulse is registered at edge E+LONG_CYC (LONG_CYC cycles after press_pulse), provided key_xd sampled 0 at every edge E..E+LONG_CYC.
- First repeat_pulse at edge E+LONG_CYC+REPEAT_CYC; subsequent ones every REPEAT_CYC cycles.
- Release: at first edge R sampling key_xd==1, release_pulse (and short_pulse if in PRESS) rise after R; held falls after R. 1-cycle latency from sample to strobe.
- Minimum press of 1 cycle low (R = E+1) is legal: press_pulse, then release_pulse+short_pulse in the next cycle.
- Release at exactly edge E+LONG_CYC: short_pulse+release_pulse, no long_pulse.

## Test plan

Bench uses LONG_CYC=8, REPEAT_CYC=4, REPEAT_EN=1.
- Reset with key_xd=1 -> all outputs 0; hold 10 cycles -> no strobes.
- key_xd low at E for 3 cycles -> press_pulse after E; release_pulse+short_pulse after E+3; held high exactly 3 cycles; no long_pulse.
- key_xd low for 8 cycles (released at edge E+8) -> short_pulse+release_pulse, no long_pulse (boundary); low for 9 cycles -> long_pulse after E+8, release_pulse after E+9, no short_pulse.
- key_xd low for 20 cycles -> long_pulse at E+8, repeat_pulse at E+12, E+16, E+20 is release edge: release_pulse only, no repeat at E+20.
- REPEAT_EN=0, key_xd low 30 cycles -> one long_pulse, zero repeat_pulse, one release_pulse.
- Press held, rst asserted at E+5 for 2 cycles with key_xd kept low -> outputs 0 during reset; after release of rst, press_pulse on first edge (key_d reset to 1), long_pulse 8 cycles later.

Source files
------------

// File: rtl/key_event_decoder.sv
// Turns the debounced active-low key level into single-cycle event strobes:
// press, release, short, long and auto-repeat, plus a held level.
module key_event_decoder #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_xd,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_short_pulse,
  output logic o_long_pulse,
  output logic o_repeat_pulse,
  output logic o_held
);

  typedef enum logic [1:0] {StIdle, StPress, StLong} state_e;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           r_state, w_state_next;
  logic             r_key_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic w_fall, w_low, w_long_hit, w_rep_hit;
  logic w_press, w_release, w_short, w_long, w_repeat, w_held;

  assign w_low      = ~i_key_xd;
  assign w_fall     = r_key_d & ~i_key_xd;
  assign w_long_hit = (r_cnt == LongLast);
  assign w_rep_hit  = (r_cnt == RepLast);

  // State, history, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= StIdle;
      r_key_d         <= 1'b1;
      r_cnt           <= '0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_short_pulse   <= 1'b0;
      o_long_pulse    <= 1'b0;
      o_repeat_pulse  <= 1'b0;
      o_held          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_key_d         <= i_key_xd;
      r_cnt           <= w_cnt_next;
      o_press_pulse   <= w_press;
      o_release_pulse <= w_release;
      o_short_pulse   <= w_short;
      o_long_pulse    <= w_long;
      o_repeat_pulse  <= w_repeat;
      o_held          <= w_held;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_fall) w_state_next = StPress;
      StPress: begin
        if (!w_low)          w_state_next = StIdle;
        else if (w_long_hit) w_state_next = StLong;
      end
      StLong:  if (!w_low) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Release is checked first so it wins over any threshold on the same edge.
  always_comb begin
    w_press    = 1'b0;
    w_release  = 1'b0;
    w_short    = 1'b0;
    w_long     = 1'b0;
    w_repeat   = 1'b0;
    w_held     = 1'b0;
    w_cnt_next = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_press    = 1'b1;
          w_held     = 1'b1;
          w_cnt_next = '0;
        end
      end
      StPress: begin
        if (!w_low) begin
          w_release = 1'b1;
          w_short   = 1'b1;
        end else begin
          w_held = 1'b1;
          if (w_long_hit) begin
            w_long     = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CntOne;
          end
        end
      end
      StLong: begin
        if (!w_low) begin
          w_release = 1'b1;
        end else begin
          w_held = 1'b1;
          if (REPEAT_EN && w_rep_hit) begin
            w_repeat   = 1'b1;
            w_cnt_next = '0;
          end else if (!w_rep_hit) begin
            // Without repeat the counter parks at the threshold instead of wrapping.
            w_cnt_next = r_cnt + CntOne;
          end
        end
      end
      default: w_cnt_next = '0;
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: two decoders (repeat on/off) share one key/reset stimulus and
// are compared every cycle against an event-timing reference model.
module tb_key_event_decoder;

  localparam int unsigned LongCyc = 8;
  localparam int unsigned RepCyc  = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_xd;
  logic [5:0] out_en, out_noen;

  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CYC(LongCyc), .REPEAT_CYC(RepCyc), .REPEAT_EN(1'b1), .CNT_W(8)
  ) u_dut_en (
    .clk(clk), .rst(rst), .i_key_xd(key_xd),
    .o_press_pulse(out_en[5]), .o_release_pulse(out_en[4]), .o_short_pulse(out_en[3]),
    .o_long_pulse(out_en[2]), .o_repeat_pulse(out_en[1]), .o_held(out_en[0])
  );

  key_event_decoder #(
    .LONG_CYC(LongCyc), .REPEAT_CYC(RepCyc), .REPEAT_EN(1'b0), .CNT_W(8)
  ) u_dut_noen (
    .clk(clk), .rst(rst), .i_key_xd(key_xd),
    .o_press_pulse(out_noen[5]), .o_release_pulse(out_noen[4]), .o_short_pulse(out_noen[3]),
    .o_long_pulse(out_noen[2]), .o_repeat_pulse(out_noen[1]), .o_held(out_noen[0])
  );

  typedef struct packed {
    logic [5:0] en;
    logic [5:0] noen;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference: k = edges elapsed since the press edge E.
  bit m_pressed[2] = '{1'b0, 1'b0};
  bit m_prev[2]    = '{1'b1, 1'b1};
  int m_k[2]       = '{0, 0};

  // Result bits: {press, release, short, long, repeat, held}.
  function automatic logic [5:0] model(input int d, input bit key, input bit en);
    logic [5:0] e = '0;
    if (!m_pressed[d]) begin
      if (!key && m_prev[d]) begin
        e[5] = 1'b1;
        e[0] = 1'b1;
        m_pressed[d] = 1'b1;
        m_k[d] = 0;
      end
    end else begin
      m_k[d]++;
      if (key) begin
        e[4] = 1'b1;
        e[3] = (m_k[d] <= int'(LongCyc));
        m_pressed[d] = 1'b0;
      end else begin
        e[0] = 1'b1;
        if (m_k[d] == int'(LongCyc)) e[2] = 1'b1;
        else if (en && m_k[d] > int'(LongCyc) && ((m_k[d] - int'(LongCyc)) % int'(RepCyc)) == 0)
          e[1] = 1'b1;
      end
    end
    m_prev[d] = key;
    return e;
  endfunction

  task automatic step(input bit key, input bit rst_v);
    exp_t e;
    @(negedge clk);
    key_xd = key;
    rst = rst_v;
    if (!rst_v) begin
      for (int d = 0; d < 2; d++) begin
        m_pressed[d] = 1'b0;
        m_prev[d] = 1'b1;
        m_k[d] = 0;
      end
      e = '0;
    end else begin
      e.en   = model(0, key, 1'b1);
      e.noen = model(1, key, 1'b0);
    end
    q.push_back(e);
  endtask

  task automatic press(input int low, input int gap);
    for (int i = 0; i < low; i++) step(1'b0, 1'b1);
    for (int i = 0; i < gap; i++) step(1'b1, 1'b1);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b (press,rel,short,long,rep,held)",
               name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("repeat_en1", out_en, e.en);
        check("repeat_en0", out_noen, e.noen);
      end
    end
  end

  initial begin : stim
    rst = 1'b0;
    key_xd = 1'b1;
    #1;
    check("reset_en1", out_en, 6'b0);
    check("reset_en0", out_noen, 6'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    press(3, 4);   // short press
    press(8, 4);   // release exactly on the long threshold edge
    press(9, 4);   // just long
    press(20, 4);  // long + repeats, release on a repeat edge
    press(30, 4);  // long hold for the no-repeat instance
    press(1, 3);   // minimum press
    // Reset mid-press with the key kept low, then resume holding.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    press(12, 4);
    for (int n = 0; n < 40; n++) press(int'($urandom_range(1, 25)), int'($urandom_range(1, 5)));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
